// File: rtl/serial_fs_sub.sv
// Bit-serial subtractor: a - b - bin is computed LSB first through one
// full-subtractor cell and a borrow flop, with valid/ready handshakes on both sides.
module serial_fs_sub #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sa_next;
  logic [WIDTH-1:0] sb_reg, sb_next;
  logic [WIDTH-1:0] sr_reg, sr_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             br_reg, br_next;
  logic             bout_reg, bout_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  logic             d;
  logic             borrow;
  logic [WIDTH-1:0] sr_shift;

  // Full-subtractor cell on the current LSBs.
  assign d      = sa_reg[0] ^ sb_reg[0] ^ br_reg;
  assign borrow = (~sa_reg[0] & sb_reg[0]) | (~(sa_reg[0] ^ sb_reg[0]) & br_reg);

  // Result register shifts right with the new difference bit entering at the MSB.
  assign sr_shift[WIDTH-1] = d;
  generate
    for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_sr
      assign sr_shift[gi] = sr_reg[gi+1];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    sa_next    = sa_reg;
    sb_next    = sb_reg;
    sr_next    = sr_reg;
    br_next    = br_reg;
    cnt_next   = cnt_reg;
    diff_next  = diff_reg;
    bout_next  = bout_reg;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          sa_next    = a;
          sb_next    = b;
          br_next    = bin;
          cnt_next   = '0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        sa_next  = sa_reg >> 1;
        sb_next  = sb_reg >> 1;
        sr_next  = sr_shift;
        br_next  = borrow;
        cnt_next = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_W'(WIDTH - 1)) begin
          diff_next  = sr_shift;
          bout_next  = borrow;
          state_next = DONE;
        end
      end
      DONE: begin
        if (done_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      sr_reg    <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sa_reg    <= sa_next;
      sb_reg    <= sb_next;
      sr_reg    <= sr_next;
      br_reg    <= br_next;
      cnt_reg   <= cnt_next;
      diff_reg  <= diff_next;
      bout_reg  <= bout_next;
    end
  end

  assign start_ready = (state_reg == IDLE);
  assign done_valid  = (state_reg == DONE);
  assign busy        = (state_reg != IDLE);
  assign diff        = diff_reg;
  assign bout        = bout_reg;

endmodule

// File: tb/tb_serial_fs_sub.sv
// Bench for serial_fs_sub: a 1-bit and an 8-bit instance, table-driven vectors
// through a scoreboard queue, plus backpressure, mid-operation reset and operand-hold sequences.
module tb_serial_fs_sub;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] diff;
    logic       bout;
  } vec_t;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
  } exp_t;

  logic clk;
  logic rst_n;

  logic       sv1, sr1, dv1, dr1, bin1, bout1, busy1;
  logic [0:0] a1, b1, diff1;
  logic       sv8, sr8, dv8, dr8, bin8, bout8, busy8;
  logic [7:0] a8, b8, diff8;

  int   checks;
  int   errors;
  exp_t sb[$];

  serial_fs_sub #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv1), .start_ready(sr1), .a(a1), .b(b1), .bin(bin1),
    .done_valid(dv1), .done_ready(dr1), .diff(diff1), .bout(bout1), .busy(busy1)
  );

  serial_fs_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv8), .start_ready(sr8), .a(a8), .b(b8), .bin(bin8),
    .done_valid(dv8), .done_ready(dr8), .diff(diff8), .bout(bout8), .busy(busy8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Runs one subtraction with done_ready held high; operands are scrambled right after acceptance.
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic bin,
                        input logic [7:0] ed, input logic eb);
    int   n;
    logic dv;
    exp_t e;
    n = 0;
    while (!((w == 1) ? sr1 : sr8) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("start_ready_wait", {31'd0, (w == 1) ? sr1 : sr8}, 32'd1);
    if (w == 1) begin
      sv1 = 1'b1; a1 = a[0]; b1 = b[0]; bin1 = bin;
    end else begin
      sv8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    end
    sb.push_back('{ed, eb});
    @(posedge clk); #1;
    sv1 = 1'b0; sv8 = 1'b0;
    if (w == 1) begin
      a1 = ~a1; b1 = ~b1; bin1 = ~bin1;
    end else begin
      a8 = ~a8; b8 = b8 ^ 8'h5B; bin8 = ~bin8;
    end
    n  = 0;
    dv = (w == 1) ? dv1 : dv8;
    while (!dv && n < w + 4) begin
      @(posedge clk); #1; n++;
      dv = (w == 1) ? dv1 : dv8;
    end
    chk("done_valid_seen", {31'd0, dv}, 32'd1);
    chk("latency", n, w);
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (w == 1) begin
        chk("diff_w1", {31'd0, diff1}, {31'd0, e.diff[0]});
        chk("bout_w1", {31'd0, bout1}, {31'd0, e.bout});
        $display("W1 a=%0h b=%0h bin=%0b -> diff=%0h bout=%0b", a[0], b[0], bin, diff1, bout1);
      end else begin
        chk("diff_w8", {24'd0, diff8}, {24'd0, e.diff});
        chk("bout_w8", {31'd0, bout8}, {31'd0, e.bout});
        $display("W8 a=%02h b=%02h bin=%0b -> diff=%02h bout=%0b", a, b, bin, diff8, bout8);
      end
    end
    @(posedge clk); #1;
    chk("done_clear", {31'd0, (w == 1) ? dv1 : dv8}, 32'd0);
  endtask

  vec_t       vecs[10];
  logic [8:0] full;
  int         n;
  exp_t       e;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    sv1 = 0; a1 = 0; b1 = 0; bin1 = 0; dr1 = 1;
    sv8 = 0; a8 = 0; b8 = 0; bin8 = 0; dr8 = 1;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    for (int i = 4; i < 10; i++) begin
      vecs[i].a    = 8'($urandom);
      vecs[i].b    = 8'($urandom);
      vecs[i].bin  = 1'($urandom);
      full         = {1'b0, vecs[i].a} - {1'b0, vecs[i].b} - {8'd0, vecs[i].bin};
      vecs[i].diff = full[7:0];
      vecs[i].bout = full[8];
    end

    repeat (2) @(posedge clk);
    #1;
    chk("rst_start_ready8", {31'd0, sr8}, 32'd1);
    chk("rst_done_valid8", {31'd0, dv8}, 32'd0);
    chk("rst_diff8", {24'd0, diff8}, 32'd0);
    chk("rst_bout8", {31'd0, bout8}, 32'd0);
    chk("rst_busy8", {31'd0, busy8}, 32'd0);
    chk("rst_start_ready1", {31'd0, sr1}, 32'd1);
    chk("rst_done_valid1", {31'd0, dv1}, 32'd0);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive: full-subtractor truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] r;
      v = 3'(i);
      r = {1'b0, v[2]} - {1'b0, v[1]} - {1'b0, v[0]};
      run_op(1, {7'd0, v[2]}, {7'd0, v[1]}, v[0], {7'd0, r[0]}, r[1]);
    end

    for (int i = 0; i < 10; i++)
      run_op(8, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout);

    // Backpressure: result held, new operands ignored while done_ready is low
    dr8 = 1'b0;
    sv8 = 1'b1; a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0;
    sb.push_back('{8'h22, 1'b0});
    @(posedge clk); #1;
    sv8 = 1'b0;
    n = 0;
    while (!dv8 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", n, 8);
    e = sb.pop_front();
    chk("bp_diff", {24'd0, diff8}, {24'd0, e.diff});
    chk("bp_bout", {31'd0, bout8}, {31'd0, e.bout});
    $display("W8 a=33 b=11 bin=0 -> diff=%02h bout=%0b (held)", diff8, bout8);
    for (int i = 0; i < 5; i++) begin
      sv8 = 1'b1; a8 = 8'hAA + 8'(i); b8 = 8'h01; bin8 = 1'b1;
      @(posedge clk); #1;
      chk("bp_hold_valid", {31'd0, dv8}, 32'd1);
      chk("bp_hold_ready", {31'd0, sr8}, 32'd0);
      chk("bp_hold_diff", {24'd0, diff8}, 32'h22);
      chk("bp_hold_bout", {31'd0, bout8}, 32'd0);
    end
    sv8 = 1'b0; dr8 = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", {31'd0, dv8}, 32'd0);
    chk("bp_release_ready", {31'd0, sr8}, 32'd1);
    chk("bp_release_busy", {31'd0, busy8}, 32'd0);
    run_op(8, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0);

    // Reset asserted for the 3rd SHIFT edge
    sv8 = 1'b1; a8 = 8'h44; b8 = 8'h01; bin8 = 1'b0;
    @(posedge clk); #1;
    sv8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_busy", {31'd0, busy8}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_ready", {31'd0, sr8}, 32'd1);
    chk("mid_rst_valid", {31'd0, dv8}, 32'd0);
    chk("mid_rst_diff", {24'd0, diff8}, 32'd0);
    chk("mid_rst_bout", {31'd0, bout8}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    $display("W8 a=44 b=01 bin=0 aborted by reset");
    run_op(8, 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
